ext_unit_arbiter: RTL and testbench
===================================

// Module: ext_unit_arbiter
// PURPOSE
//  Shares one 16->32 immediate-extension datapath between two requesters: the decode stage (req0)
//  and the load-alignment unit (req1). Round-robin arbitration, valid/ready handshakes on both
//  sides, one registered result stage. Sits between decode/load-align and the execute operand muxes.
// PARAMETERS
//  TAG_W   4   width of the opaque tag carried with each request and returned with its result
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst_n       in   1      synchronous active-low reset
//  req0_valid  in   1      requester 0 has a request
//  req0_ready  out  1      requester 0 request accepted this cycle when valid&ready
//  req0_data   in   16     value to extend
//  req0_mode   in   2      00 SIGN, 01 ZERO, 10 UPPER, 11 BYTE/reserved
//  req0_tag    in   TAG_W  returned unchanged with the result
//  req1_*      -    -      identical set for requester 1
//  out_valid   out  1      result register holds a valid result
//  out_ready   in   1      consumer accepts result when out_valid&out_ready
//  out_data    out  32     extended result
//  out_src     out  1      0 = result belongs to req0, 1 = req1
//  out_tag     out  TAG_W  tag of the request that produced out_data
//  err_mode    out  1      sticky: a reserved mode was accepted (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_src=0, out_tag=0, err_mode=0,
//   rr_last=1 (so req0 has priority first). req*_ready are combinational and are 0 while rst_n=0.
//  State: EMPTY (out_valid=0) / FULL (out_valid=1).
//  can_load = !out_valid | out_ready. Only one request is accepted per cycle.
//  Grant: if can_load and exactly one req valid -> grant it. Both valid -> grant the one not equal
//   to rr_last. reqN_ready = can_load & grant==N; the loser's ready is 0 and it must hold its inputs.
//  On grant: next cycle out_valid=1, out_data=ext(data,mode), out_src=N, out_tag=tag, rr_last=N.
//   Latency: exactly 1 cycle from accept to out_valid.
//  FULL & out_ready & new grant: result replaced back-to-back; throughput 1/cycle.
//  FULL & out_ready & no grant -> EMPTY. FULL & !out_ready: out_* held stable, all ready=0.
//  rr_last updates only on an actual grant; a requester alone never loses priority state.
//  Extension rules (exact): SIGN  = {{16{d[15]}}, d}  (0x8000 -> 0xFFFF8000, 0x7FFF -> 0x00007FFF)
//   ZERO = {16'h0000, d};  UPPER = {d, 16'h0000};  mode 11 per CONFIGURATION.
//  Reset mid-operation: pending result discarded, no handshake completes that cycle.
// CONFIGURATION
//  Macro EXT_BYTE_EN:
//   defined:     mode 11 = BYTE = {{24{d[7]}}, d[7:0]}; d[15:8] ignored; err_mode stays 0.
//   not defined: mode 11 handled as ZERO; err_mode set to 1 on acceptance, held until reset.
// STRUCTURE
//  Package ext_pkg: typedef ext_mode_e {EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_UPPER=2'b10,
//   EXT_BYTE=2'b11}; localparam EXT_IN_W=16, EXT_OUT_W=32.
//  Sub-module ext_core: purely combinational (data, mode) -> 32-bit result, owns the EXT_BYTE_EN
//   switch; arbiter, handshake and output register live in ext_unit_arbiter.
// TESTING
//  1 req0 only, d=0x8000 SIGN, out_ready=1 -> next cycle out_data=0xFFFF8000, out_src=0, tag echoed.
//  2 req0+req1 valid every cycle, out_ready=1 -> grants alternate 0,1,0,1; one result per cycle.
//  3 out_ready=0 for 3 cycles while FULL -> out_* stable, both ready=0; release -> next grant next cycle.
//  4 d=0x1234 UPPER -> 0x12340000; d=0x8001 ZERO -> 0x00008001; d=0x7FFF SIGN -> 0x00007FFF.
//  5 d=0x0080 mode 11: with EXT_BYTE_EN -> 0xFFFFFF80, err_mode=0; without -> 0x00000080, err_mode=1.
//  6 rst_n=0 while FULL and both valid -> out_valid=0, err_mode=0, first grant after reset is req0.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared types for the immediate-extension arbiter slice.
package ext_pkg;

  localparam int EXT_IN_W  = 16;
  localparam int EXT_OUT_W = 32;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_BYTE  = 2'b11
  } ext_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/ext_core.sv
// Combinational 16->32 extension. Build option EXT_BYTE_EN turns mode 11 into
// byte sign-extension; otherwise mode 11 behaves as ZERO and is flagged reserved.
module ext_core
  import ext_pkg::*;
(
  input  logic [EXT_IN_W-1:0]  data,
  input  logic [1:0]           mode,
  output logic [EXT_OUT_W-1:0] result,
  output logic                 reserved
);

  always_comb begin
    result   = '0;
    reserved = 1'b0;
    case (ext_mode_e'(mode))
      EXT_SIGN:  result = {{16{data[15]}}, data};
      EXT_ZERO:  result = {16'h0000, data};
      EXT_UPPER: result = {data, 16'h0000};
      EXT_BYTE: begin
`ifdef EXT_BYTE_EN
        result = {{24{data[7]}}, data[7:0]};
`else
        result   = {16'h0000, data};
        reserved = 1'b1;
`endif
      end
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ext_unit_arbiter.sv
// Round-robin arbiter sharing one ext_core between two requesters, with a
// single registered result stage. Mode 11 behaviour follows EXT_BYTE_EN.
module ext_unit_arbiter
  import ext_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [EXT_IN_W-1:0]  req0_data,
  input  logic [1:0]           req0_mode,
  input  logic [TAG_W-1:0]     req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [EXT_IN_W-1:0]  req1_data,
  input  logic [1:0]           req1_mode,
  input  logic [TAG_W-1:0]     req1_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXT_OUT_W-1:0] out_data,
  output logic                 out_src,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 err_mode
);

  out_state_e state, state_next;
  logic rr_last;
  logic can_load, load, grant_src;
  logic [EXT_IN_W-1:0]  sel_data;
  logic [1:0]           sel_mode;
  logic [TAG_W-1:0]     sel_tag;
  logic [EXT_OUT_W-1:0] ext_result;
  logic                 ext_reserved;

  assign out_valid = (state == ST_FULL);

  ext_core u_ext_core (
    .data     (sel_data),
    .mode     (sel_mode),
    .result   (ext_result),
    .reserved (ext_reserved)
  );

  always_comb begin
    state_next = state;
    grant_src  = 1'b0;
    can_load   = (state == ST_EMPTY) || out_ready;
    // Contention goes to whoever did not win last; a lone requester always wins.
    if (req0_valid && req1_valid) grant_src = ~rr_last;
    else if (req1_valid)          grant_src = 1'b1;
    load       = rst_n && can_load && (req0_valid || req1_valid);
    req0_ready = load && !grant_src;
    req1_ready = load && grant_src;
    sel_data   = grant_src ? req1_data : req0_data;
    sel_mode   = grant_src ? req1_mode : req0_mode;
    sel_tag    = grant_src ? req1_tag  : req0_tag;
    if (load)                                state_next = ST_FULL;
    else if (state == ST_FULL && out_ready)  state_next = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_src  <= 1'b0;
      out_tag  <= '0;
      err_mode <= 1'b0;
      rr_last  <= 1'b1;
    end else begin
      state <= state_next;
      if (load) begin
        out_data <= ext_result;
        out_src  <= grant_src;
        out_tag  <= sel_tag;
        rr_last  <= grant_src;
        if (ext_reserved) err_mode <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ext_unit_arbiter.sv
// Directed vector bench for ext_unit_arbiter: table of single-cycle vectors
// followed by hand-written stall and reset sequences.
module tb_ext_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [1:0]  req0_mode, req1_mode;
  logic [3:0]  req0_tag, req1_tag;
  logic        out_valid, out_ready, out_src, err_mode;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  int n_cmp = 0;
  int n_err = 0;

`ifdef EXT_BYTE_EN
  localparam logic [31:0] BYTE_RES = 32'hFFFF_FF80;
  localparam logic        BYTE_ERR = 1'b0;
`else
  localparam logic [31:0] BYTE_RES = 32'h0000_0080;
  localparam logic        BYTE_ERR = 1'b1;
`endif

  always #5 clk = ~clk;

  ext_unit_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_mode(req0_mode), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_mode(req1_mode), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_tag(out_tag), .err_mode(err_mode)
  );

  typedef struct {
    logic        v0; logic [15:0] d0; logic [1:0] m0; logic [3:0] t0;
    logic        v1; logic [15:0] d1; logic [1:0] m1; logic [3:0] t1;
    logic        ordy;
    logic        r0; logic r1;
    logic        ov; logic [31:0] od; logic os; logic [3:0] ot; logic oe;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [15:0] d0, input logic [1:0] m0,
                       input logic [3:0] t0, input logic v1, input logic [15:0] d1,
                       input logic [1:0] m1, input logic [3:0] t1, input logic ordy);
    req0_valid = v0; req0_data = d0; req0_mode = m0; req0_tag = t0;
    req1_valid = v1; req1_data = d1; req1_mode = m1; req1_tag = t1;
    out_ready  = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ov, input logic [31:0] od,
                         input logic os, input logic [3:0] ot, input logic oe);
    chk({name, ".valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({name, ".data"},  out_data, od);
    chk({name, ".src"},   {31'b0, out_src}, {31'b0, os});
    chk({name, ".tag"},   {28'b0, out_tag}, {28'b0, ot});
    chk({name, ".err"},   {31'b0, err_mode}, {31'b0, oe});
  endtask

  task automatic chk_rdy(input string name, input logic r0, input logic r1);
    chk({name, ".ready0"}, {31'b0, req0_ready}, {31'b0, r0});
    chk({name, ".ready1"}, {31'b0, req1_ready}, {31'b0, r1});
  endtask

  initial begin
    // After reset rr_last=1, so req0 wins the first contention.
    vec[0] = '{1'b1,16'h8000,2'b00,4'h3, 1'b0,16'h0000,2'b00,4'h0, 1'b1,
               1'b1,1'b0, 1'b1,32'hFFFF_8000,1'b0,4'h3,1'b0};
    vec[1] = '{1'b1,16'h1234,2'b10,4'h1, 1'b1,16'h8001,2'b01,4'h2, 1'b1,
               1'b0,1'b1, 1'b1,32'h0000_8001,1'b1,4'h2,1'b0};
    vec[2] = '{1'b1,16'h1234,2'b10,4'h1, 1'b1,16'h8001,2'b01,4'h2, 1'b1,
               1'b1,1'b0, 1'b1,32'h1234_0000,1'b0,4'h1,1'b0};
    vec[3] = '{1'b1,16'h7FFF,2'b00,4'h4, 1'b1,16'h0080,2'b11,4'h5, 1'b1,
               1'b0,1'b1, 1'b1,BYTE_RES,1'b1,4'h5,BYTE_ERR};
    vec[4] = '{1'b1,16'h7FFF,2'b00,4'h4, 1'b1,16'h0080,2'b11,4'h5, 1'b1,
               1'b1,1'b0, 1'b1,32'h0000_7FFF,1'b0,4'h4,BYTE_ERR};
    vec[5] = '{1'b0,16'h0000,2'b00,4'h0, 1'b0,16'h0000,2'b00,4'h0, 1'b1,
               1'b0,1'b0, 1'b0,32'h0000_7FFF,1'b0,4'h4,BYTE_ERR};
    vec[6] = '{1'b0,16'h0000,2'b00,4'h0, 1'b1,16'h00FF,2'b01,4'h6, 1'b1,
               1'b0,1'b1, 1'b1,32'h0000_00FF,1'b1,4'h6,BYTE_ERR};
    vec[7] = '{1'b0,16'h0000,2'b00,4'h0, 1'b1,16'hFFFF,2'b00,4'h7, 1'b1,
               1'b0,1'b1, 1'b1,32'hFFFF_FFFF,1'b1,4'h7,BYTE_ERR};

    rst_n = 1'b0;
    drive(1'b0,'0,'0,'0, 1'b0,'0,'0,'0, 1'b0);
    tick(); tick();
    chk_out("reset", 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      drive(vec[i].v0, vec[i].d0, vec[i].m0, vec[i].t0,
            vec[i].v1, vec[i].d1, vec[i].m1, vec[i].t1, vec[i].ordy);
      #1;
      chk_rdy($sformatf("vec%0d", i), vec[i].r0, vec[i].r1);
      tick();
      chk_out($sformatf("vec%0d", i), vec[i].ov, vec[i].od, vec[i].os, vec[i].ot, vec[i].oe);
    end

    // Stall: FULL with out_ready low holds everything and blocks both requesters.
    drive(1'b1,16'hAAAA,2'b01,4'h8, 1'b1,16'h5555,2'b10,4'h9, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_rdy($sformatf("stall%0d", c), 1'b0, 1'b0);
      tick();
      chk_out($sformatf("stall%0d", c), 1'b1, 32'hFFFF_FFFF, 1'b1, 4'h7, BYTE_ERR);
    end
    out_ready = 1'b1;
    #1;
    chk_rdy("release", 1'b1, 1'b0);
    tick();
    chk_out("release", 1'b1, 32'h0000_AAAA, 1'b0, 4'h8, BYTE_ERR);

    // Reset while FULL and both requesting: nothing accepted, state cleared.
    rst_n = 1'b0;
    #1;
    chk_rdy("rst_mid", 1'b0, 1'b0);
    tick();
    chk_out("rst_mid", 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    tick();
    chk_out("post_rst", 1'b1, 32'h0000_AAAA, 1'b0, 4'h8, 1'b0);

    drive(1'b0,'0,'0,'0, 1'b0,'0,'0,'0, 1'b1);
    tick();
    chk("drain.valid", {31'b0, out_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
